// File: rtl/control_step_sequencer.sv
// control_step_sequencer: programmable T-state table sequencer driving datapath control words,
// with memory-wait stalls, early END, implicit wrap and halt-after-instruction.
module control_step_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int CTRL_W    = 32,
    parameter int STEP_W    = 3,
    parameter int CNT_W     = 16
) (
    input  logic              i_clock,
    input  logic              i_clear,
    input  logic              i_start,
    input  logic              i_halt,
    input  logic              i_mem_ready,
    input  logic              i_cfg_we,
    input  logic [STEP_W-1:0] i_cfg_addr,
    input  logic [CTRL_W+1:0] i_cfg_data,
    output logic [CTRL_W-1:0] o_ctrl_out,
    output logic [STEP_W-1:0] o_step,
    output logic              o_busy,
    output logic              o_instr_done,
    output logic              o_cfg_err,
    output logic [CNT_W-1:0]  o_instr_count
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            r_state;
    logic [CTRL_W+1:0] r_table [NUM_STEPS];
    logic [CTRL_W-1:0] r_ctrl;
    logic [STEP_W-1:0] r_step;
    logic              r_done;
    logic              r_err;
    logic              r_stop_pend;
    logic [CNT_W-1:0]  r_count;

    logic [STEP_W-1:0] w_next;
    logic              w_stall;
    logic              w_last;
    logic              w_addr_ok;

    assign w_next    = r_step + 1'b1;
    assign w_stall   = r_table[r_step][CTRL_W+1] && !i_mem_ready;
    assign w_last    = r_table[r_step][CTRL_W] || r_step == STEP_W'(NUM_STEPS - 1);
    assign w_addr_ok = int'(i_cfg_addr) < NUM_STEPS;

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state     <= S_IDLE;
            r_ctrl      <= '0;
            r_step      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_stop_pend <= 1'b0;
            r_count     <= '0;
            for (int i = 0; i < NUM_STEPS; i++) r_table[i] <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= i_cfg_we && (r_state == S_RUN || !w_addr_ok);
            if (r_state == S_IDLE) begin
                r_ctrl <= '0;
                r_step <= '0;
                if (i_cfg_we) begin
                    if (w_addr_ok) r_table[i_cfg_addr] <= i_cfg_data;
                end else if (i_start && !i_halt) begin
                    r_state <= S_RUN;
                    r_ctrl  <= r_table[0][CTRL_W-1:0];
                end
            end else begin
                // halt is latched on every edge that does not retire the instruction
                if (w_stall || !w_last) r_stop_pend <= r_stop_pend | i_halt;
                if (!w_stall && w_last) begin
                    r_done  <= 1'b1;
                    r_count <= r_count + 1'b1;
                    r_step  <= '0;
                    if (i_halt || r_stop_pend) begin
                        r_state     <= S_IDLE;
                        r_ctrl      <= '0;
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_ctrl <= r_table[0][CTRL_W-1:0];
                    end
                end else if (!w_stall) begin
                    r_step <= w_next;
                    r_ctrl <= r_table[w_next][CTRL_W-1:0];
                end
            end
        end
    end

    assign o_ctrl_out    = r_ctrl;
    assign o_step        = r_step;
    assign o_busy        = r_state == S_RUN;
    assign o_instr_done  = r_done;
    assign o_cfg_err     = r_err;
    assign o_instr_count = r_count;
endmodule

// File: tb/tb_control_step_sequencer.sv
// tb_control_step_sequencer: vector-table bench with an expected-result queue for the sequencer.
module tb_control_step_sequencer;
    localparam int NS = 8, CW = 32, SW = 3, NW = 16;

    localparam logic [CW-1:0] T0 = 32'h0000_000F;
    localparam logic [CW-1:0] T1 = 32'h0000_0030;
    localparam logic [CW-1:0] T2 = 32'h0000_00C0;
    localparam logic [CW-1:0] T3 = 32'h0000_0700;
    localparam logic [CW-1:0] T4 = 32'h0000_1800;
    localparam logic [CW-1:0] T5 = 32'h0000_E000;

    logic          clk = 1'b0;
    logic          clear, start, halt, mem_ready, cfg_we;
    logic [SW-1:0] cfg_addr;
    logic [CW+1:0] cfg_data;
    logic [CW-1:0] ctrl_out;
    logic [SW-1:0] step;
    logic          busy, instr_done, cfg_err;
    logic [NW-1:0] instr_count;

    typedef struct {
        logic          we;
        logic [SW-1:0] addr;
        logic [CW+1:0] data;
        logic          st;
        logic          ht;
        logic          mr;
        logic [CW-1:0] e_ctrl;
        logic [SW-1:0] e_step;
        logic          e_busy;
        logic          e_done;
        logic          e_err;
        logic [NW-1:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [SW-1:0] step;
        logic          busy;
        logic          done;
        logic          err;
        logic [NW-1:0] cnt;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    control_step_sequencer #(.NUM_STEPS(NS), .CTRL_W(CW), .STEP_W(SW), .CNT_W(NW)) dut (
        .i_clock(clk), .i_clear(clear), .i_start(start), .i_halt(halt),
        .i_mem_ready(mem_ready), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
        .i_cfg_data(cfg_data), .o_ctrl_out(ctrl_out), .o_step(step), .o_busy(busy),
        .o_instr_done(instr_done), .o_cfg_err(cfg_err), .o_instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic add(input logic we, input int addr, input logic [CW+1:0] data,
                       input logic st, input logic ht, input logic mr,
                       input logic [CW-1:0] ec, input int es, input logic eb,
                       input logic ed, input logic ee, input int en);
        vq.push_back('{we, SW'(addr), data, st, ht, mr, ec, SW'(es), eb, ed, ee, NW'(en)});
    endtask

    task automatic check(input string name, input exp_t e);
        compared++;
        if (ctrl_out !== e.ctrl || step !== e.step || busy !== e.busy ||
            instr_done !== e.done || cfg_err !== e.err || instr_count !== e.cnt) begin
            mismatched++;
            $display("FAIL %s: got ctrl=%h step=%0d busy=%b done=%b err=%b cnt=%0d want ctrl=%h step=%0d busy=%b done=%b err=%b cnt=%0d",
                     name, ctrl_out, step, busy, instr_done, cfg_err, instr_count,
                     e.ctrl, e.step, e.busy, e.done, e.err, e.cnt);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        cfg_we = v.we; cfg_addr = v.addr; cfg_data = v.data;
        start = v.st; halt = v.ht; mem_ready = v.mr;
        sb.push_back('{v.e_ctrl, v.e_step, v.e_busy, v.e_done, v.e_err, v.e_cnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(name, e);
    endtask

    initial begin
        exp_t r;
        clear = 1'b1; start = 0; halt = 0; mem_ready = 1; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", '{'0, '0, 1'b0, 1'b0, 1'b0, '0});
        clear = 1'b0;

        // branch-style program
        add(1, 0, {2'b00, T0}, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, {2'b10, T1}, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 2, {2'b00, T2}, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 3, {2'b00, T3}, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 4, {2'b00, T4}, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 5, {2'b01, T5}, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, '0, 1, 0, 1, T0, 0, 1, 0, 0, 0);
        add(0, 0, '0, 0, 0, 1, T1, 1, 1, 0, 0, 0);
        add(0, 0, '0, 0, 0, 1, T2, 2, 1, 0, 0, 0);
        add(0, 0, '0, 0, 0, 1, T3, 3, 1, 0, 0, 0);
        add(0, 0, '0, 0, 0, 1, T4, 4, 1, 0, 0, 0);
        add(0, 0, '0, 0, 0, 1, T5, 5, 1, 0, 0, 0);
        add(0, 0, '0, 0, 0, 1, T0, 0, 1, 1, 0, 1);
        // stall at T1 for 4 cycles, halt at T2, rejected write at T3
        add(0, 0, '0, 0, 0, 1, T1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, '0, 0, 0, 0, T1, 1, 1, 0, 0, 1);
        add(0, 0, '0, 0, 0, 1, T2, 2, 1, 0, 0, 1);
        add(0, 0, '0, 0, 1, 1, T3, 3, 1, 0, 0, 1);
        add(1, 0, {2'b11, 32'hFFFF_FFFF}, 0, 0, 1, T4, 4, 1, 0, 1, 1);
        add(0, 0, '0, 0, 0, 1, T5, 5, 1, 0, 0, 1);
        add(0, 0, '0, 0, 0, 1, 0, 0, 0, 1, 0, 2);
        // write + start together, start blocked by halt, then clean start
        add(1, 6, {2'b00, 32'h0000_ABCD}, 1, 0, 1, 0, 0, 0, 0, 0, 2);
        add(0, 0, '0, 1, 1, 1, 0, 0, 0, 0, 0, 2);
        add(0, 0, '0, 1, 0, 1, T0, 0, 1, 0, 0, 2);
        add(0, 0, '0, 0, 0, 1, T1, 1, 1, 0, 0, 2);
        add(0, 0, '0, 0, 0, 1, T2, 2, 1, 0, 0, 2);
        add(0, 0, '0, 0, 0, 1, T3, 3, 1, 0, 0, 2);
        add(0, 0, '0, 0, 0, 1, T4, 4, 1, 0, 0, 2);
        add(0, 0, '0, 0, 0, 1, T5, 5, 1, 0, 0, 2);
        add(0, 0, '0, 0, 1, 1, 0, 0, 0, 1, 0, 3);
        // no END bits: implicit wrap after T7, mem_ready low is irrelevant
        for (int i = 0; i < NS; i++) add(1, i, {2'b00, 32'h100 + i}, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        add(0, 0, '0, 1, 0, 0, 32'h100, 0, 1, 0, 0, 3);
        for (int k = 1; k < 16; k++)
            add(0, 0, '0, 0, 0, 0, 32'h100 + (k % 8), k % 8, 1, k == 8, 0, k >= 8 ? 4 : 3);
        add(0, 0, '0, 0, 1, 0, 0, 0, 0, 1, 0, 5);
        // run to T3 before the mid-run clear
        add(0, 0, '0, 1, 0, 1, 32'h100, 0, 1, 0, 0, 5);
        for (int k = 1; k <= 3; k++) add(0, 0, '0, 0, 0, 1, 32'h100 + k, k, 1, 0, 0, 5);

        for (int i = 0; i < vq.size(); i++) apply($sformatf("vec%0d", i), vq[i]);

        #2 clear = 1'b1;
        #1 check("clear_mid_run", '{'0, '0, 1'b0, 1'b0, 1'b0, '0});
        clear = 1'b0;
        apply("table_cleared_t0", '{0, '0, '0, 1, 0, 1, '0, '0, 1, 0, 0, '0});
        apply("table_cleared_t1", '{0, '0, '0, 0, 0, 1, '0, SW'(1), 1, 0, 0, '0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
